// File: rtl/bpred_pkg.sv
// Shared definitions for the bimodal/gshare branch predictor: counter encodings
// and saturating step helpers.
package bpred_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] CTR_RESET = WNT;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter with enable and synchronous reset; one per BHT entry.
module sat_counter2
  import bpred_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  output logic [1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= CTR_RESET;
    end else if (en) begin
      value <= up ? sat_inc(value) : sat_dec(value);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch history table of 2-bit counters with F->D prediction register and stats.
// Build option: define BPRED_GSHARE_EN to hash the fetch index with a global history register.
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             branchD,
  input  logic             equalD,
  output logic             predTakenF,
  output logic             brbitD,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredCount
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;

  logic [ENTRIES-1:0][1:0] bht;
  logic [IDX_BITS-1:0]     idx_pc;
  logic [IDX_BITS-1:0]     idxF;
  logic [IDX_BITS-1:0]     idxD;
  logic                    train;
  logic                    unused_pc_bits;

  assign idx_pc         = pcF[IDX_BITS+1:2];
  assign unused_pc_bits = ^{pcF[31:IDX_BITS+2], pcF[1:0]};
  assign train          = branchD & ~stallD;

`ifdef BPRED_GSHARE_EN
  logic [IDX_BITS-1:0] ghr;

  // History shifts only on real training updates, never on stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (train) begin
      ghr <= {ghr[IDX_BITS-2:0], equalD};
    end
  end

  assign idxF = idx_pc ^ ghr;
`else
  assign idxF = idx_pc;
`endif

  // Each entry trains only when the resolving branch's index matches it.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
    sat_counter2 u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (train && (idxD == IDX_BITS'(i))),
      .up    (equalD),
      .value (bht[i])
    );
  end

  assign predTakenF = bht[idxF][1];

  // F->D register: stall holds, flush clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      brbitD <= 1'b0;
      idxD   <= '0;
    end else if (stallD) begin
      brbitD <= brbitD;
      idxD   <= idxD;
    end else if (flushD) begin
      brbitD <= 1'b0;
      idxD   <= '0;
    end else begin
      brbitD <= predTakenF;
      idxD   <= idxF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branchCount  <= '0;
      mispredCount <= '0;
    end else if (train) begin
      if (branchCount != '1) begin
        branchCount <= branchCount + CNT_W'(1);
      end
      if ((equalD != brbitD) && (mispredCount != '1)) begin
        mispredCount <= mispredCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test for branch_predictor: reset, training, saturation, stall/flush,
// index hashing (default bimodal, or gshare when BPRED_GSHARE_EN is defined).
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pcF;
  logic        stallD;
  logic        flushD;
  logic        branchD;
  logic        equalD;
  logic        predTakenF;
  logic        brbitD;
  logic [15:0] branchCount;
  logic [15:0] mispredCount;

  int total;
  int bad;

  branch_predictor #(.IDX_BITS(6), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcF          (pcF),
    .stallD       (stallD),
    .flushD       (flushD),
    .branchD      (branchD),
    .equalD       (equalD),
    .predTakenF   (predTakenF),
    .brbitD       (brbitD),
    .branchCount  (branchCount),
    .mispredCount (mispredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    pcF     = 32'h40;
    stallD  = 1'b0;
    flushD  = 1'b0;
    branchD = 1'b0;
    equalD  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_pred", 32'(predTakenF), 0);
    chk("rst_brbit", 32'(brbitD), 0);
    chk("rst_bc", 32'(branchCount), 0);
    chk("rst_mp", 32'(mispredCount), 0);

`ifdef BPRED_GSHARE_EN
    // Load idx 0x10 into decode, then two taken updates make GHR = 000011.
    tick();
    chk("g_brbit0", 32'(brbitD), 0);
    branchD = 1'b1; equalD = 1'b1;
    tick();
    tick();
    branchD = 1'b0;
    #1;
    chk("g_bc2", 32'(branchCount), 2);
    chk("g_mp2", 32'(mispredCount), 2);
    chk("g_pred13_pre", 32'(predTakenF), 0);
    tick();
    branchD = 1'b1; equalD = 1'b1;
    tick();
    branchD = 1'b0;
    chk("g_bc3", 32'(branchCount), 3);
    chk("g_mp3", 32'(mispredCount), 3);
    pcF = 32'h50;
    #1;
    chk("g_entry13_trained", 32'(predTakenF), 1);
    pcF = 32'h40;
    #1;
    chk("g_entry17_untouched", 32'(predTakenF), 0);
    pcF = 32'h5C;
    #1;
    chk("g_entry10_strong", 32'(predTakenF), 1);
`else
    // Test 1: prediction for pc 0x40 reaches decode.
    tick();
    chk("t1_brbit", 32'(brbitD), 0);

    // Test 2: two taken resolutions of entry 0x10.
    branchD = 1'b1; equalD = 1'b1;
    tick();
    chk("t2_bc1", 32'(branchCount), 1);
    chk("t2_mp1", 32'(mispredCount), 1);
    chk("t2_pred_wt", 32'(predTakenF), 1);
    branchD = 1'b0;
    tick();
    chk("t2_brbit1", 32'(brbitD), 1);
    branchD = 1'b1;
    tick();
    chk("t2_bc2", 32'(branchCount), 2);
    chk("t2_mp_still1", 32'(mispredCount), 1);
    chk("t2_pred_st", 32'(predTakenF), 1);

    // Test 3: saturation at ST, then drain to SNT.
    repeat (4) tick();
    chk("t3_bc6", 32'(branchCount), 6);
    chk("t3_mp1", 32'(mispredCount), 1);
    equalD = 1'b0;
    tick();
    chk("t3_bc7", 32'(branchCount), 7);
    chk("t3_mp2", 32'(mispredCount), 2);
    chk("t3_pred_wt", 32'(predTakenF), 1);
    repeat (4) tick();
    chk("t3_bc11", 32'(branchCount), 11);
    chk("t3_mp4", 32'(mispredCount), 4);
    chk("t3_pred_snt", 32'(predTakenF), 0);
    tick();
    chk("t3_bc12", 32'(branchCount), 12);
    chk("t3_mp4b", 32'(mispredCount), 4);
    branchD = 1'b0;
    tick();
    chk("t3_brbit0", 32'(brbitD), 0);
    branchD = 1'b1; equalD = 1'b1;
    tick();
    chk("t3_floor_pred", 32'(predTakenF), 0);
    chk("t3_bc13", 32'(branchCount), 13);
    tick();
    chk("t3_pred_wt2", 32'(predTakenF), 1);
    chk("t3_mp6", 32'(mispredCount), 6);
    branchD = 1'b0;
    tick();
    chk("t3_brbit1", 32'(brbitD), 1);

    // Test 4: three stalled cycles with a branch, then one real update.
    pcF = 32'h80; stallD = 1'b1; branchD = 1'b1; equalD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_brbit_held", 32'(brbitD), 1);
      chk("t4_bc_held", 32'(branchCount), 14);
    end
    chk("t4_mp_held", 32'(mispredCount), 6);
    stallD = 1'b0;
    tick();
    chk("t4_bc15", 32'(branchCount), 15);
    chk("t4_mp7", 32'(mispredCount), 7);
    chk("t4_brbit_new", 32'(brbitD), 0);
    branchD = 1'b0; pcF = 32'h40;
    #1;
    chk("t4_entry_wnt", 32'(predTakenF), 0);
    tick();
    branchD = 1'b1; equalD = 1'b1;
    tick();
    chk("t4_single_update", 32'(predTakenF), 1);
    chk("t4_bc16", 32'(branchCount), 16);
    chk("t4_mp8", 32'(mispredCount), 8);

    // Test 5: flush clears, stall beats flush.
    branchD = 1'b0; flushD = 1'b1;
    tick();
    chk("t5_flush", 32'(brbitD), 0);
    flushD = 1'b0;
    tick();
    chk("t5_reload", 32'(brbitD), 1);
    pcF = 32'h80; stallD = 1'b1; flushD = 1'b1;
    tick();
    chk("t5_stall_over_flush", 32'(brbitD), 1);
    stallD = 1'b0; flushD = 1'b0;

    // Test 6: bimodal indexing trains 0x10, leaves 0x13 alone.
    pcF = 32'h4C;
    #1;
    chk("t6_entry13_untouched", 32'(predTakenF), 0);
    pcF = 32'h40;
    #1;
    chk("t6_entry10_trained", 32'(predTakenF), 1);

    // Reset during an update wins.
    reset = 1'b1; branchD = 1'b1; equalD = 1'b1;
    tick();
    reset = 1'b0; branchD = 1'b0;
    #1;
    chk("mrst_bc", 32'(branchCount), 0);
    chk("mrst_mp", 32'(mispredCount), 0);
    chk("mrst_brbit", 32'(brbitD), 0);
    chk("mrst_pred", 32'(predTakenF), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
